vend_ctrl_param: RTL
====================

Name: vend_ctrl_param

Overview:
Parameterised vending controller, next generation of the fixed six-item machine. Item count, price list, per-item stock and credit width are parameters. Change and refunds are paid out one coin at a time through a ready/valid coin-hopper handshake, using greedy selection. Sits between the coin acceptor / keypad front end and the dispenser and hopper drivers.

Parameters:
N_ITEMS, 6, number of selectable items (1..16)
ITEM_W, 3, width of item index
CREDIT_W, 6, width of credit and change arithmetic
PRICE_LIST, {20,20,10,10,5,2} packed CREDIT_W each, price of item i at slice i
MAX_CREDIT, 50, credit ceiling; must be < 2^CREDIT_W
STOCK_W, 4, per-item stock counter width
INIT_STOCK, 5, stock of every item after reset
TIMEOUT_CYC, 1000, idle cycles with nonzero credit before auto-refund

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
coin_valid  in  1  coin present this cycle
coin  in  3  coin code: 001=1, 010=2, 011=5, 100=10
sel_valid  in  1  item selection strobe
sel  in  ITEM_W  item index 0..N_ITEMS-1
cancel  in  1  cancel transaction
restock_valid  in  1  restock strobe
restock_item  in  ITEM_W  item to restock
restock_qty  in  STOCK_W  units added
chg_ready  in  1  hopper accepts a coin
coin_reject  out  1  one-cycle pulse: coin returned, not credited
sel_nack  out  1  one-cycle pulse: selection refused
nack_code  out  2  01 invalid index, 10 sold out, 11 insufficient credit
dispense_valid  out  1  one-cycle dispense pulse
dispense_item  out  ITEM_W  item being dispensed
chg_valid  out  1  change coin offered
chg_coin  out  3  change coin code (same encoding as coin)
state  out  2  00 ACCEPT, 01 DISPENSE, 10 CHANGE
credit  out  CREDIT_W  current credit, or remaining change in CHANGE

Behaviour:
- Reset: all outputs 0, state ACCEPT, credit 0, timeout counter 0, every stock counter = INIT_STOCK. Reset during DISPENSE or CHANGE abandons the transaction; owed change is discarded.
- ACCEPT, same-cycle priority: cancel > sel_valid > coin_valid.
- cancel: if credit > 0, go to CHANGE with remaining = credit. If credit = 0, no effect. A coin presented in the same cycle is rejected.
- sel_valid, checked in order:
  - sel >= N_ITEMS: nack 01.
  - stock[sel] = 0: nack 10.
  - credit < price: nack 11.
  - Otherwise accept: go to DISPENSE, latch item, remaining = credit - price, decrement stock[sel]. A coin in the same cycle is rejected.
  - On any nack, state is unchanged and a same-cycle coin is processed normally.
- coin_valid: illegal code (000, 101-111) -> coin_reject. If credit + value > MAX_CREDIT -> coin_reject, credit unchanged. Otherwise credit += value. Sum is computed at CREDIT_W+1 bits; no wrap.
- DISPENSE, one cycle: dispense_valid = 1 and dispense_item = latched item. Next state is CHANGE if remaining > 0, else ACCEPT with credit 0.
- CHANGE:
  - chg_coin = largest denomination <= remaining; chg_valid held high.
  - On chg_valid & chg_ready: remaining -= value. When remaining reaches 0: chg_valid drops, state ACCEPT, credit 0.
  - chg_coin is stable while chg_ready is low.
  - coin_valid here -> coin_reject. sel_valid and cancel are ignored, no nack.
- restock: accepted in any state; stock[restock_item] += restock_qty, saturating at 2^STOCK_W-1. Out-of-range index is ignored. A decrement and restock of the same item in the same cycle apply both.
- Timeout: in ACCEPT with credit > 0, the counter increments each cycle without a coin, sel or cancel strobe, and clears on any such strobe or when credit = 0. Reaching TIMEOUT_CYC enters CHANGE with remaining = credit.
- Latency: coin -> credit visible next cycle; accepted sel -> dispense_valid next cycle; first change coin offered one cycle after DISPENSE.

Decomposition:
- Package vend_pkg: state enum, coin code constants, coin value function (code -> value), greedy denomination function (remaining -> code), nack codes.
- Sub-module vend_change_payout: owns the remaining register, greedy selection and the chg handshake; load/start in, done out.

Test Plan:
- Insert 10 then 5 (credit 15), select item 2 -> dispense_valid one cycle with item 2; chg_coin 011 once; state ACCEPT, credit 0, stock[2] = 4.
- Credit 2, select item 4 -> nack 11, credit 2; cancel -> single chg_coin 010, credit 0.
- Buy item 0 five times with exact 2 each -> no change phase; sixth attempt -> nack 10; restock item 0 qty 3 -> purchase succeeds.
- Five 10 coins -> credit 50; sixth 10 -> coin_reject, credit 50; code 111 -> coin_reject.
- Credit 13, buy item 1 (remaining 8) with chg_ready low 3 cycles at first coin -> coins 011, 010, 001 in order, chg_coin stable while stalled.
- TIMEOUT_CYC = 16: insert 1, idle 16 cycles -> chg_coin 001. Separately, assert rst mid-CHANGE -> chg_valid 0 immediately, credit 0, all stock = INIT_STOCK.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and coin helpers for the parameterised vending controller.
// Coin codes, nack codes, state encoding and greedy change selection live here.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_ACCEPT   = 2'b00,
    ST_DISPENSE = 2'b01,
    ST_CHANGE   = 2'b10
  } state_t;

  localparam logic [2:0] COIN_NONE = 3'b000;
  localparam logic [2:0] COIN_1    = 3'b001;
  localparam logic [2:0] COIN_2    = 3'b010;
  localparam logic [2:0] COIN_5    = 3'b011;
  localparam logic [2:0] COIN_10   = 3'b100;

  localparam logic [1:0] NACK_NONE     = 2'b00;
  localparam logic [1:0] NACK_INDEX    = 2'b01;
  localparam logic [1:0] NACK_SOLD_OUT = 2'b10;
  localparam logic [1:0] NACK_CREDIT   = 2'b11;

  localparam int unsigned VAL_W = 4;

  // Illegal codes map to zero, which callers treat as "reject".
  function automatic logic [VAL_W-1:0] coin_value(input logic [2:0] code);
    case (code)
      COIN_1:  return 4'd1;
      COIN_2:  return 4'd2;
      COIN_5:  return 4'd5;
      COIN_10: return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] greedy_coin(input logic [15:0] amount);
    if (amount >= 16'd10)      return COIN_10;
    else if (amount >= 16'd5)  return COIN_5;
    else if (amount >= 16'd2)  return COIN_2;
    else if (amount != 16'd0)  return COIN_1;
    else                       return COIN_NONE;
  endfunction

endpackage

// File: rtl/vend_change_payout.sv
// Change hopper driver: holds the amount still owed and offers one greedy coin
// at a time over a ready/valid handshake; o_done marks the final accepted coin.
module vend_change_payout #(
  parameter int unsigned CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [CREDIT_W-1:0] i_amount,
  input  logic                i_chg_ready,
  output logic                o_chg_valid,
  output logic [2:0]          o_chg_coin,
  output logic [CREDIT_W-1:0] o_remaining,
  output logic                o_done
);
  import vend_pkg::*;

  logic [CREDIT_W-1:0] r_rem;
  logic                r_valid;
  logic [2:0]          r_coin;
  logic [CREDIT_W-1:0] w_rem_nxt;
  logic                w_take;

  always_comb begin
    w_take    = r_valid & i_chg_ready;
    w_rem_nxt = r_rem - CREDIT_W'(coin_value(r_coin));
  end

  // Coin code is registered so it cannot move while the hopper stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_coin  <= COIN_NONE;
    end else if (i_load) begin
      r_rem   <= i_amount;
      r_valid <= (i_amount != '0);
      r_coin  <= greedy_coin(16'(i_amount));
    end else if (w_take) begin
      r_rem   <= w_rem_nxt;
      r_valid <= (w_rem_nxt != '0);
      r_coin  <= greedy_coin(16'(w_rem_nxt));
    end
  end

  assign o_chg_valid = r_valid;
  assign o_chg_coin  = r_coin;
  assign o_remaining = r_rem;
  assign o_done      = w_take && (w_rem_nxt == '0);

endmodule

// File: rtl/vend_ctrl_param.sv
// Parameterised vending controller: credit accumulation, item selection with
// stock tracking, idle timeout refund, and change payout via vend_change_payout.
module vend_ctrl_param #(
  parameter int unsigned N_ITEMS     = 6,
  parameter int unsigned ITEM_W      = 3,
  parameter int unsigned CREDIT_W    = 6,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICE_LIST =
    {6'd20, 6'd20, 6'd10, 6'd10, 6'd5, 6'd2},
  parameter int unsigned MAX_CREDIT  = 50,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned INIT_STOCK  = 5,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [2:0]          coin,
  input  logic                sel_valid,
  input  logic [ITEM_W-1:0]   sel,
  input  logic                cancel,
  input  logic                restock_valid,
  input  logic [ITEM_W-1:0]   restock_item,
  input  logic [STOCK_W-1:0]  restock_qty,
  input  logic                chg_ready,
  output logic                coin_reject,
  output logic                sel_nack,
  output logic [1:0]          nack_code,
  output logic                dispense_valid,
  output logic [ITEM_W-1:0]   dispense_item,
  output logic                chg_valid,
  output logic [2:0]          chg_coin,
  output logic [1:0]          state,
  output logic [CREDIT_W-1:0] credit
);
  import vend_pkg::*;

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [TO_W-1:0]     r_to;
  logic [ITEM_W-1:0]   r_item;
  logic                r_coin_reject;
  logic                r_sel_nack;
  logic [1:0]          r_nack_code;
  logic                r_dispense_valid;
  logic [STOCK_W-1:0]  r_stock     [N_ITEMS];
  logic [STOCK_W-1:0]  w_stock_nxt [N_ITEMS];
  logic [STOCK_W:0]    w_stock_sum [N_ITEMS];

  logic [CREDIT_W-1:0] w_price;
  logic [STOCK_W-1:0]  w_sel_stock;
  logic [CREDIT_W:0]   w_sum;
  logic                w_accept, w_credit_nz, w_in_range, w_buy;
  logic                w_coin_add, w_any_strobe, w_timeout, w_load;
  logic                w_done;
  logic [CREDIT_W-1:0] w_pay_rem;

  always_comb begin
    w_price     = '0;
    w_sel_stock = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (32'(sel) == i) begin
        w_price     = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
        w_sel_stock = r_stock[i];
      end
    end
    w_accept     = (r_state == ST_ACCEPT);
    w_credit_nz  = (r_credit != '0);
    w_in_range   = (32'(sel) < N_ITEMS);
    w_sum        = {1'b0, r_credit} + (CREDIT_W+1)'(coin_value(coin));
    w_buy        = w_accept && !cancel && sel_valid && w_in_range &&
                   (w_sel_stock != '0) && (r_credit >= w_price);
    w_coin_add   = w_accept && coin_valid && !cancel && !w_buy &&
                   (coin_value(coin) != '0) &&
                   (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    w_any_strobe = coin_valid || sel_valid || cancel;
    w_timeout    = w_accept && w_credit_nz && !w_any_strobe &&
                   (r_to == TO_W'(TIMEOUT_CYC - 1));
    // r_credit already holds the amount owed whenever the payout is loaded.
    w_load       = (w_accept && cancel && w_credit_nz) || w_timeout ||
                   ((r_state == ST_DISPENSE) && w_credit_nz);
  end

  // Purchase decrement and restock may hit the same item in one cycle.
  always_comb begin
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      w_stock_sum[i] = {1'b0, r_stock[i]};
      if (w_buy && (32'(sel) == i))
        w_stock_sum[i] = w_stock_sum[i] - (STOCK_W+1)'(1);
      if (restock_valid && (32'(restock_item) == i))
        w_stock_sum[i] = w_stock_sum[i] + {1'b0, restock_qty};
      w_stock_nxt[i] = w_stock_sum[i][STOCK_W] ? '1 : w_stock_sum[i][STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (rst) r_stock[i] <= STOCK_W'(INIT_STOCK);
      else     r_stock[i] <= w_stock_nxt[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_ACCEPT;
      r_credit         <= '0;
      r_to             <= '0;
      r_item           <= '0;
      r_coin_reject    <= 1'b0;
      r_sel_nack       <= 1'b0;
      r_nack_code      <= NACK_NONE;
      r_dispense_valid <= 1'b0;
    end else begin
      r_coin_reject    <= 1'b0;
      r_sel_nack       <= 1'b0;
      r_nack_code      <= NACK_NONE;
      r_dispense_valid <= 1'b0;
      case (r_state)
        ST_ACCEPT: begin
          if (w_coin_add)      r_credit      <= w_sum[CREDIT_W-1:0];
          else if (coin_valid) r_coin_reject <= 1'b1;
          if (w_load) begin
            r_state  <= ST_CHANGE;
            r_credit <= '0;
          end else if (w_buy) begin
            r_state          <= ST_DISPENSE;
            r_item           <= sel;
            r_credit         <= r_credit - w_price;
            r_dispense_valid <= 1'b1;
          end else if (sel_valid && !cancel) begin
            r_sel_nack <= 1'b1;
            if (!w_in_range)             r_nack_code <= NACK_INDEX;
            else if (w_sel_stock == '0)  r_nack_code <= NACK_SOLD_OUT;
            else                         r_nack_code <= NACK_CREDIT;
          end
          if (w_any_strobe || !w_credit_nz || w_timeout) r_to <= '0;
          else                                           r_to <= r_to + TO_W'(1);
        end
        ST_DISPENSE: begin
          if (coin_valid) r_coin_reject <= 1'b1;
          r_state  <= w_load ? ST_CHANGE : ST_ACCEPT;
          r_credit <= '0;
          r_to     <= '0;
        end
        ST_CHANGE: begin
          if (coin_valid) r_coin_reject <= 1'b1;
          if (w_done)     r_state       <= ST_ACCEPT;
          r_to <= '0;
        end
        default: r_state <= ST_ACCEPT;
      endcase
    end
  end

  vend_change_payout #(
    .CREDIT_W (CREDIT_W)
  ) u_payout (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_amount    (r_credit),
    .i_chg_ready (chg_ready),
    .o_chg_valid (chg_valid),
    .o_chg_coin  (chg_coin),
    .o_remaining (w_pay_rem),
    .o_done      (w_done)
  );

  assign coin_reject    = r_coin_reject;
  assign sel_nack       = r_sel_nack;
  assign nack_code      = r_nack_code;
  assign dispense_valid = r_dispense_valid;
  assign dispense_item  = r_item;
  assign state          = r_state;
  assign credit         = (r_state == ST_CHANGE) ? w_pay_rem : r_credit;

endmodule
